// File: rtl/frame_config_pkg.sv
// frame_config_pkg: state encodings, header field positions and idle row value for frame_config_writer.
package frame_config_pkg;
`ifdef FRAME_CONFIG_WRITER_CHECKSUM_EN
  typedef enum logic [1:0] {S_HDR = 2'd0, S_DATA = 2'd1, S_CHK = 2'd2, S_STROBE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_HDR = 2'd0, S_DATA = 2'd1, S_STROBE = 2'd3} state_t;
`endif
  localparam int HDR_COL_MSB = 31;
  localparam int HDR_COL_LSB = 16;
  localparam int IDLE_ROW = 0;
endpackage

// File: rtl/frame_config_writer.sv
// frame_config_writer: streams header + per-row words into a configuration frame and strobes its address.
// Optional checksum word after the data is enabled by FRAME_CONFIG_WRITER_CHECKSUM_EN.
module frame_config_writer
  import frame_config_pkg::*;
#(
  parameter int FrameBitsPerRow  = 32,
  parameter int RowSelectWidth   = 5,
  parameter int NumberOfRows     = 16,
  parameter int FrameSelectWidth = 5,
  parameter int MaxFramesPerCol  = 20
) (
  input  logic                          CLK,
  input  logic                          resetn,
  input  logic [FrameBitsPerRow-1:0]    Word_I,
  input  logic                          Valid_I,
  output logic                          Ready_O,
  output logic [FrameBitsPerRow-1:0]    FrameData_O,
  output logic [RowSelectWidth-1:0]     RowSelect_O,
  output logic [16+FrameSelectWidth-1:0] FrameAddr_O,
  output logic                          FrameStrobe_O,
  output logic                          Err_O
);
  state_t state_q, state_d;
  logic [RowSelectWidth-1:0] row_q, row_sel_q;
  logic [FrameBitsPerRow-1:0] data_q;
  logic [16+FrameSelectWidth-1:0] addr_q;
  logic strobe_q, err_q, bad_q;
  logic acc, last, hdr_bad, chk_ok;
  assign acc = Valid_I & Ready_O;
  assign last = row_q == RowSelectWidth'(NumberOfRows);
  assign hdr_bad = 32'(Word_I[FrameSelectWidth-1:0]) >= 32'(MaxFramesPerCol);
`ifdef FRAME_CONFIG_WRITER_CHECKSUM_EN
  logic [FrameBitsPerRow-1:0] xor_q;
  assign chk_ok = Word_I == xor_q;
  always_ff @(posedge CLK) begin
    if (!resetn) xor_q <= '0;
    else if (acc && state_q == S_HDR) xor_q <= Word_I;
    else if (acc && state_q == S_DATA) xor_q <= xor_q ^ Word_I;
  end
`else
  assign chk_ok = 1'b1;
`endif
  always_ff @(posedge CLK) begin
    if (!resetn) state_q <= S_HDR;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_HDR:    state_d = acc ? S_DATA : S_HDR;
`ifdef FRAME_CONFIG_WRITER_CHECKSUM_EN
      S_DATA:   state_d = (acc && last) ? S_CHK : S_DATA;
      S_CHK:    state_d = acc ? ((chk_ok && !bad_q) ? S_STROBE : S_HDR) : S_CHK;
`else
      S_DATA:   state_d = (acc && last) ? (bad_q ? S_HDR : S_STROBE) : S_DATA;
`endif
      S_STROBE: state_d = S_HDR;
      default:  state_d = S_HDR;
    endcase
  end
  always_comb Ready_O = resetn && state_q != S_STROBE;
  // Rows of an out-of-range frame are consumed but never selected.
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      row_q     <= RowSelectWidth'(1);
      row_sel_q <= RowSelectWidth'(IDLE_ROW);
      data_q    <= '0;
      addr_q    <= '0;
      strobe_q  <= 1'b0;
      err_q     <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      strobe_q  <= state_q == S_STROBE;
      row_sel_q <= RowSelectWidth'(IDLE_ROW);
      if (acc && state_q == S_HDR) begin
        addr_q <= {Word_I[HDR_COL_MSB:HDR_COL_LSB], Word_I[FrameSelectWidth-1:0]};
        bad_q  <= hdr_bad;
        err_q  <= err_q | hdr_bad;
        row_q  <= RowSelectWidth'(1);
      end
      if (acc && state_q == S_DATA) begin
        if (!bad_q) begin
          data_q    <= Word_I;
          row_sel_q <= row_q;
        end
        row_q <= row_q + RowSelectWidth'(1);
      end
`ifdef FRAME_CONFIG_WRITER_CHECKSUM_EN
      if (acc && state_q == S_CHK && !chk_ok) err_q <= 1'b1;
`endif
    end
  end
  assign FrameData_O   = data_q;
  assign RowSelect_O   = row_sel_q;
  assign FrameAddr_O   = addr_q;
  assign FrameStrobe_O = strobe_q;
  assign Err_O         = err_q;
endmodule

// File: tb/tb_frame_config_writer.sv
// tb_frame_config_writer: random and directed frames checked cycle by cycle against a frame-position model.
module tb_frame_config_writer;
`ifdef FRAME_CONFIG_WRITER_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic CLK = 1'b0, resetn = 1'b0, valid = 1'b0;
  logic [31:0] word = '0;
  logic ready, strobe, err;
  logic [31:0] fdata;
  logic [4:0] rsel;
  logic [20:0] faddr;
  int total = 0, bad = 0;
  int m_pos = 0;
  bit m_bad = 0, m_strb = 0;
  logic [31:0] m_xor = '0, e_fd = '0;
  logic [4:0] e_row = '0;
  logic [20:0] e_addr = '0;
  logic e_strobe = 1'b0, e_err = 1'b0;

  frame_config_writer dut (
    .CLK(CLK), .resetn(resetn), .Word_I(word), .Valid_I(valid), .Ready_O(ready),
    .FrameData_O(fdata), .RowSelect_O(rsel), .FrameAddr_O(faddr),
    .FrameStrobe_O(strobe), .Err_O(err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: m_pos is the position of the next word in the frame (0 header, 1..16 rows, 17 checksum).
  always @(posedge CLK) begin
    if (!resetn) begin
      m_pos = 0; m_bad = 0; m_strb = 0; e_fd = '0; e_row = '0;
      e_addr = '0; e_strobe = 0; e_err = 0;
    end else begin
      e_strobe = m_strb;
      e_row = '0;
      if (m_strb) m_strb = 0;
      else if (valid) begin
        if (m_pos == 0) begin
          e_addr = {word[31:16], word[4:0]};
          m_bad = word[4:0] >= 20;
          e_err = e_err | m_bad;
          m_xor = word;
          m_pos = 1;
        end else if (m_pos <= 16) begin
          if (!m_bad) begin e_fd = word; e_row = 5'(m_pos); end
          m_xor = m_xor ^ word;
          m_pos++;
          if (m_pos == 17 && !CHK) begin m_pos = 0; m_strb = !m_bad; end
        end else begin
          m_pos = 0;
          if (word == m_xor) m_strb = !m_bad;
          else e_err = 1;
        end
      end
    end
    #1;
    check("ready", 64'(ready), 64'(resetn && !m_strb));
    check("rowsel", 64'(rsel), 64'(e_row));
    check("fdata", 64'(fdata), 64'(e_fd));
    check("faddr", 64'(faddr), 64'(e_addr));
    check("strobe", 64'(strobe), 64'(e_strobe));
    check("err", 64'(err), 64'(e_err));
  end

  task automatic send(input logic [31:0] w, input int gap);
    bit took = 0;
    repeat (gap) begin valid = 0; @(negedge CLK); end
    word = w; valid = 1;
    for (int t = 0; t < 20 && !took; t++) begin
      @(posedge CLK);
      took = ready;
    end
    if (!took) check("accept_timeout", 64'(0), 64'(1));
    @(negedge CLK);
    valid = 0;
  endtask

  task automatic pulse_reset();
    valid = 0; resetn = 0;
    @(negedge CLK);
    resetn = 1;
  endtask

  task automatic send_frame(input logic [31:0] hdr, input bit rnd, input int stall_row,
                            input int abort_after, input bit corrupt);
    logic [31:0] x, d;
    send(hdr, 0);
    x = hdr;
    for (int i = 1; i <= 16; i++) begin
      d = rnd ? $urandom : 32'hA0 + 32'(i - 1);
      x ^= d;
      send(d, (i == stall_row + 1) ? 3 : (rnd && $urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      if (i == abort_after) begin pulse_reset(); return; end
    end
    if (CHK) send(corrupt ? x ^ 32'h1 : x, 0);
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    logic [31:0] hdr;
    repeat (3) @(negedge CLK);
    resetn = 1;
    @(negedge CLK);
    send_frame(32'h0003_0002, 0, -1, 0, 0);
    send_frame(32'h0003_0002, 0, 5, 0, 0);
    send_frame(32'h0001_0019, 0, -1, 0, 0);
    check("err_sticky", 64'(err), 64'(1));
    send_frame(32'h0007_0004, 0, -1, 8, 0);
    send_frame(32'h0007_0004, 0, -1, 0, 0);
    send_frame(32'h0005_0001, 1, -1, 0, 1);
    pulse_reset();
    for (int n = 0; n < 25; n++) begin
      hdr = {16'($urandom), 11'($urandom),
             5'($urandom_range(0, 9) == 0 ? $urandom_range(20, 31) : $urandom_range(0, 19))};
      send_frame(hdr, 1, -1, $urandom_range(0, 7) == 0 ? $urandom_range(1, 16) : 0,
                 $urandom_range(0, 3) == 0);
    end
    repeat (5) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
